// File: rtl/uart_rx_dma.sv
//------------------------------------------------------------------------------
// uart_rx_dma
// UART receiver with an RX FIFO, a small register window and a one-word-per-
// two-clocks DMA engine that writes received bytes to memory.
// Revision: 1.0
//------------------------------------------------------------------------------
`default_nettype none

module uart_rx_dma #(
   parameter int          WORD_LEN   = 32,
   parameter int          FIFO_DEPTH = 16,
   parameter logic [31:0] BASE_ADDR  = 32'h1000,
   parameter int          DIV_W      = 16
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                rx,
   input  logic                wen_core,
   input  logic                ren_core,
   input  logic [WORD_LEN-1:0] addr_d_core,
   input  logic [WORD_LEN-1:0] wdata_core,
   output logic [WORD_LEN-1:0] rdata_uart,
   output logic                intr,
   output logic                wen_uart,
   output logic [WORD_LEN-1:0] addr_d_uart,
   output logic [WORD_LEN-1:0] wdata_uart
);

   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;

   localparam logic [WORD_LEN-1:0] A_CTRL   = WORD_LEN'(BASE_ADDR + 32'h0);
   localparam logic [WORD_LEN-1:0] A_DIV    = WORD_LEN'(BASE_ADDR + 32'h4);
   localparam logic [WORD_LEN-1:0] A_STATUS = WORD_LEN'(BASE_ADDR + 32'h8);
   localparam logic [WORD_LEN-1:0] A_DMA    = WORD_LEN'(BASE_ADDR + 32'hC);
   localparam logic [WORD_LEN-1:0] A_RXDATA = WORD_LEN'(BASE_ADDR + 32'h10);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
   typedef enum logic {D_IDLE, D_WRITE} dma_state_t;

   // configuration and status registers
   logic [3:0]          ctrl;
   logic [DIV_W-1:0]    div;
   logic [WORD_LEN-1:0] dma_addr;
   logic                ovr, ferr;

   // receive path
   logic                sync1, sync2, rx_prev;
   rx_state_t           rx_state;
   logic [DIV_W-1:0]    cnt;
   logic [2:0]          bit_idx;
   logic [7:0]          shreg;

   // FIFO
   logic [7:0]          mem [FIFO_DEPTH];
   logic [AW-1:0]       wr_ptr, rd_ptr;
   logic [CW-1:0]       count;

   dma_state_t          dma_state;

   logic en, dma_en, fall, empty, full, dma_wr;
   logic sel_ctrl, sel_div, sel_status, sel_dma, sel_rxdata;
   logic bit_tick, half_tick, stop_done, push, pop, core_pop, ovr_set, ferr_set;
   logic [2:0]       last_idx;
   logic [DIV_W-1:0] eff_div, half_div;
   logic [DIV_W:0]   cnt_inc;
   logic [7:0]       head;
   logic [WORD_LEN-1:0] head_ext, status_v;
   logic unused_wdata;

   assign unused_wdata = ^wdata_core;

   assign en       = ctrl[0];
   assign dma_en   = ctrl[1];
   assign last_idx = 3'd4 + {1'b0, ctrl[3:2]};
   // divisors below 2 would make the half-bit wait zero, so clamp them
   assign eff_div  = (div < DIV_W'(2)) ? DIV_W'(2) : div;
   assign half_div = eff_div >> 1;
   assign cnt_inc  = {1'b0, cnt} + (DIV_W+1)'(1);
   // >= rather than == so a divisor shrunk mid-frame cannot strand the counter
   assign bit_tick  = cnt_inc >= {1'b0, eff_div};
   assign half_tick = cnt_inc >= {1'b0, half_div};
   assign fall      = rx_prev & ~sync2;

   assign empty    = (count == '0);
   assign full     = (count == CW'(FIFO_DEPTH));
   assign head     = mem[rd_ptr];
   assign head_ext = {{(WORD_LEN-8){1'b0}}, head};
   assign dma_wr   = (dma_state == D_WRITE);

   assign sel_ctrl   = (addr_d_core == A_CTRL);
   assign sel_div    = (addr_d_core == A_DIV);
   assign sel_status = (addr_d_core == A_STATUS);
   assign sel_dma    = (addr_d_core == A_DMA);
   assign sel_rxdata = (addr_d_core == A_RXDATA);

   // the DMA engine owns the pop during its write cycle, so the core never pops then
   assign core_pop  = ren_core & sel_rxdata & ~dma_en & ~empty & ~dma_wr;
   assign pop       = dma_wr | core_pop;
   assign stop_done = en & (rx_state == STOP) & bit_tick;
   assign push      = stop_done & sync2 & (~full | pop);
   assign ovr_set   = stop_done & sync2 & full & ~pop;
   assign ferr_set  = stop_done & ~sync2;

   assign intr        = dma_wr;
   assign wen_uart    = dma_wr;
   assign addr_d_uart = dma_wr ? dma_addr : '0;
   assign wdata_uart  = dma_wr ? head_ext : '0;

   // register read mux; quiet (zero) unless the core is actually reading
   always_comb begin
      status_v       = '0;
      status_v[7:0]  = 8'(count);
      status_v[8]    = ovr;
      status_v[9]    = ferr;
      status_v[10]   = empty;
      rdata_uart     = '0;
      if (ren_core) begin
         if (sel_ctrl)        rdata_uart = {{(WORD_LEN-4){1'b0}}, ctrl};
         else if (sel_div)    rdata_uart = WORD_LEN'(div);
         else if (sel_status) rdata_uart = status_v;
         else if (sel_dma)    rdata_uart = dma_addr;
         else if (sel_rxdata) rdata_uart = empty ? '0 : head_ext;
      end
   end

   // two-flop synchroniser plus one history flop for falling-edge detection
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         sync1   <= 1'b1;
         sync2   <= 1'b1;
         rx_prev <= 1'b1;
      end else begin
         sync1   <= rx;
         sync2   <= sync1;
         rx_prev <= sync2;
      end
   end

   // receive state machine: start-bit check at half bit, then one sample per bit
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rx_state <= IDLE;
         cnt      <= '0;
         bit_idx  <= '0;
         shreg    <= '0;
      end else if (!en) begin
         rx_state <= IDLE;
         cnt      <= '0;
      end else begin
         case (rx_state)
            IDLE: begin
               cnt <= '0;
               if (fall) begin
                  rx_state <= START;
                  shreg    <= '0;
               end
            end
            START: begin
               if (half_tick) begin
                  cnt      <= '0;
                  bit_idx  <= '0;
                  rx_state <= sync2 ? IDLE : DATA;
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            DATA: begin
               if (bit_tick) begin
                  cnt            <= '0;
                  shreg[bit_idx] <= sync2;
                  if (bit_idx >= last_idx) rx_state <= STOP;
                  else                     bit_idx  <= bit_idx + 3'd1;
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
            default: begin
               if (bit_tick) begin
                  cnt      <= '0;
                  rx_state <= IDLE;
               end else begin
                  cnt <= cnt + DIV_W'(1);
               end
            end
         endcase
      end
   end

   // FIFO storage
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= shreg;
   end

   // FIFO pointers and occupancy
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + AW'(1);
         if (pop)  rd_ptr <= rd_ptr + AW'(1);
         if (push && !pop)      count <= count + CW'(1);
         else if (pop && !push) count <= count - CW'(1);
      end
   end

   // control registers; core write to DMA_ADDR beats the post-write increment
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ctrl     <= '0;
         div      <= DIV_W'(868);
         dma_addr <= '0;
         ovr      <= 1'b0;
         ferr     <= 1'b0;
      end else begin
         if (wen_core && sel_ctrl) ctrl <= wdata_core[3:0];
         if (wen_core && sel_div)  div  <= DIV_W'(wdata_core);
         if (wen_core && sel_dma)  dma_addr <= {wdata_core[WORD_LEN-1:2], 2'b00};
         else if (dma_wr)          dma_addr <= dma_addr + WORD_LEN'(4);
         if (ovr_set)                                 ovr  <= 1'b1;
         else if (wen_core && sel_status && wdata_core[8]) ovr  <= 1'b0;
         if (ferr_set)                                ferr <= 1'b1;
         else if (wen_core && sel_status && wdata_core[9]) ferr <= 1'b0;
      end
   end

   // DMA engine: one write cycle, then one idle cycle
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         dma_state <= D_IDLE;
      end else begin
         case (dma_state)
            D_IDLE:  if (dma_en && !empty) dma_state <= D_WRITE;
            default: dma_state <= D_IDLE;
         endcase
      end
   end

endmodule

`default_nettype wire
